// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, drives the IF/ID register.
// Latency: 1 cycle from imem_ack to IF/ID for zero-wait memory.
// Backpressure: freeze holds PC and IF/ID; a late response parks in a one-word skid buffer.
//
// Ports: clk/rst (async active-low), freeze (hazard hold), branch_taken/branch_addr (redirect),
//        imem_req/imem_addr/imem_ack/imem_rdata (fetch handshake),
//        if_instr/if_pc/if_valid (IF/ID register, if_instr=0 is a NOP), fetch_busy (WAIT or HOLD).
// Optional: define IF_PERF_CNT_EN to add saturating stall_cycles and flush_count outputs.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  output logic               fetch_busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cycles,
  output logic [15:0]        flush_count
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               discard_q, discard_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic [INSTR_W-1:0] instr_d;
  logic [ADDR_W-1:0]  ifpc_d;
  logic               valid_d;
  logic [ADDR_W-1:0]  pc_plus4;
  logic               word_vld;
  logic [INSTR_W-1:0] word;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  // Gated by rst so the bus is idle while reset is held; the first request
  // appears as soon as reset is released.
  assign imem_req   = rst && (state_q != S_HOLD);
  // While waiting, the address stays on the issued value even if a branch
  // has already moved pc.
  assign imem_addr  = (state_q == S_WAIT) ? addr_q : pc_q;
  assign fetch_busy = (state_q != S_REQ);

  // A word is available either from memory or, once freeze drops, from the skid buffer.
  assign word_vld = (state_q == S_HOLD) ? !freeze : imem_ack;
  assign word     = (state_q == S_HOLD) ? skid_q : imem_rdata;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    skid_d    = skid_q;
    instr_d   = if_instr;
    ifpc_d    = if_pc;
    valid_d   = if_valid;
    if (branch_taken) begin
      // Flush beats freeze: IF/ID goes to NOP and any parked word is dropped.
      pc_d    = branch_addr;
      instr_d = '0;
      ifpc_d  = '0;
      valid_d = 1'b0;
      skid_d  = '0;
      if (state_q == S_WAIT && !imem_ack) begin
        // Outstanding request must complete at its old address; its data is stale.
        state_d   = S_WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = S_REQ;
        discard_d = 1'b0;
      end
    end else if (discard_q) begin
      if (imem_ack) begin
        discard_d = 1'b0;
        state_d   = S_REQ;
      end
      if (!freeze) begin
        instr_d = '0;
        ifpc_d  = '0;
        valid_d = 1'b0;
      end
    end else if (freeze) begin
      if (state_q != S_HOLD && imem_ack) begin
        skid_d  = imem_rdata;
        state_d = S_HOLD;
      end else if (state_q == S_REQ) begin
        state_d = S_WAIT;
      end
    end else if (word_vld) begin
      instr_d = word;
      ifpc_d  = pc_plus4;
      valid_d = 1'b1;
      pc_d    = pc_plus4;
      skid_d  = '0;
      state_d = S_REQ;
    end else begin
      // Nothing to present: insert a bubble so no instruction is seen twice.
      instr_d = '0;
      ifpc_d  = '0;
      valid_d = 1'b0;
      if (state_q == S_REQ) state_d = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      discard_q <= 1'b0;
      skid_q    <= '0;
      if_instr  <= '0;
      if_pc     <= '0;
      if_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      if (state_q == S_REQ) addr_q <= pc_q;
      discard_q <= discard_d;
      skid_q    <= skid_d;
      if_instr  <= instr_d;
      if_pc     <= ifpc_d;
      if_valid  <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((freeze || state_q == S_WAIT) && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (branch_taken && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
